// File: rtl/mvau_pkg.sv
// Shared configuration for the MVU processing-element datapath.
// Holds the default lane count, fold factor and data widths, and the
// derived lane-sum width used by both the adder tree and the accumulator.
// No ports (package).
package mvau_pkg;

  localparam int SIMD_DEF  = 4;   // product lanes per beat
  localparam int SF_DEF    = 3;   // beats folded into one dot product
  localparam int TDSTI_DEF = 8;   // signed product width per lane
  localparam int TDSTO_DEF = 16;  // signed accumulator / output width

  // A sum of simd signed tdsti-bit values never needs more than
  // tdsti + clog2(simd) bits, so the lane sum cannot overflow.
  function automatic int sum_width(input int tdsti, input int simd);
    return tdsti + $clog2(simd);
  endfunction

  localparam int SUM_W_DEF = sum_width(TDSTI_DEF, SIMD_DEF);

endpackage

// File: rtl/mvu_pe_adders.sv
// Combinational SIMD-lane reduction for the MVU processing element.
// Every lane is sign-extended to SUM_W bits and summed in a balanced binary
// tree; the result is registered by the parent.
// Ports:
//   prod_i : packed signed lane products, lane i at [i*TDstI +: TDstI]
//   sum_o  : signed sum of all lanes, SUM_W bits
module mvu_pe_adders
  import mvau_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int SUM_W = sum_width(TDSTI_DEF, SIMD_DEF)
) (
  input  logic [SIMD*TDstI-1:0] prod_i,
  output logic signed [SUM_W-1:0] sum_o
);

  // The tree is built over the next power of two; unused leaves are zero.
  localparam int LVL = $clog2(SIMD);
  localparam int P   = 1 << LVL;

  // Heap layout: node k has children 2k+1 and 2k+2, leaves start at P-1.
  logic signed [SUM_W-1:0] node [2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < SIMD) begin : g_lane
      assign node[P-1+i] = SUM_W'(signed'(prod_i[i*TDstI +: TDstI]));
    end else begin : g_pad
      assign node[P-1+i] = '0;
    end
  end

  for (genvar k = 0; k < P-1; k++) begin : g_node
    assign node[k] = node[2*k+1] + node[2*k+2];
  end

  assign sum_o = node[0];

endmodule

// File: rtl/mvu_pe_acc.sv
// MVU processing-element accumulator.
// Reduces SIMD lane products to one lane sum per valid beat (stage 1), then
// folds SF consecutive valid beats into one signed dot product (stage 2).
// out_v pulses for one cycle two cycles after the edge that sampled the SF-th
// beat; out_acc holds the result until the next completion. Gaps in in_v
// stall the fold; there is no backpressure.
// Build option: define MVU_PE_ACC_SAT_EN to clamp every accumulator update to
// the signed TDstO range; otherwise accumulation wraps modulo 2^TDstO.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   in_v    : product beat valid
//   in_prod : packed signed lane products, lane i at [i*TDstI +: TDstI]
//   out_v   : one-cycle completion pulse
//   out_acc : signed dot product, TDstO bits
module mvu_pe_acc
  import mvau_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int SF    = SF_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDstO = TDSTO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_v,
  input  logic [SIMD*TDstI-1:0] in_prod,
  output logic                  out_v,
  output logic [TDstO-1:0]      out_acc
);

  localparam int SUM_W = sum_width(TDstI, SIMD);
  localparam int CNT_W = (SF > 1) ? $clog2(SF) : 1;

`ifdef MVU_PE_ACC_SAT_EN
  // One guard bit above the wider operand makes the raw sum exact.
  localparam int EXT_W = ((TDstO > SUM_W) ? TDstO : SUM_W) + 1;
  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-TDstO+1){1'b0}}, {(TDstO-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-TDstO+1){1'b1}}, {(TDstO-1){1'b0}}};
  localparam logic signed [TDstO-1:0] OUT_MAX = {1'b0, {(TDstO-1){1'b1}}};
  localparam logic signed [TDstO-1:0] OUT_MIN = {1'b1, {(TDstO-1){1'b0}}};

  function automatic logic signed [TDstO-1:0] acc_update(
    input logic signed [TDstO-1:0] base,
    input logic signed [SUM_W-1:0] add
  );
    logic signed [EXT_W-1:0] s;
    s = EXT_W'(base) + EXT_W'(add);
    if (s > ACC_MAX)      return OUT_MAX;
    else if (s < ACC_MIN) return OUT_MIN;
    else                  return s[TDstO-1:0];
  endfunction
`else
  function automatic logic signed [TDstO-1:0] acc_update(
    input logic signed [TDstO-1:0] base,
    input logic signed [SUM_W-1:0] add
  );
    // Two's-complement wrap: just keep the low TDstO bits.
    return base + TDstO'(add);
  endfunction
`endif

  logic signed [SUM_W-1:0] lane_sum;
  logic signed [SUM_W-1:0] sum_r;
  logic                    sum_v;
  logic signed [TDstO-1:0] acc;
  logic signed [TDstO-1:0] acc_base;
  logic signed [TDstO-1:0] acc_d;
  logic [CNT_W-1:0]        sf_cnt;
  logic                    last_beat;
  logic signed [TDstO-1:0] out_acc_q;
  logic                    out_v_q;

  mvu_pe_adders #(
    .SIMD  (SIMD),
    .TDstI (TDstI),
    .SUM_W (SUM_W)
  ) u_adders (
    .prod_i (in_prod),
    .sum_o  (lane_sum)
  );

  // Stage 1: register the lane sum of each valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_v <= 1'b0;
      sum_r <= '0;
    end else begin
      sum_v <= in_v;
      if (in_v) sum_r <= lane_sum;
    end
  end

  // Stage 2: fold SF lane sums; beat index 0 restarts from zero so nothing
  // carries over between back-to-back groups.
  always_comb begin
    last_beat = (sf_cnt == CNT_W'(SF-1));
    acc_base  = (sf_cnt == '0) ? '0 : acc;
    acc_d     = acc_update(acc_base, sum_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sf_cnt    <= '0;
      out_acc_q <= '0;
      out_v_q   <= 1'b0;
    end else begin
      out_v_q <= 1'b0;
      if (sum_v) begin
        acc <= acc_d;
        if (last_beat) begin
          sf_cnt    <= '0;
          out_acc_q <= acc_d;
          out_v_q   <= 1'b1;
        end else begin
          sf_cnt <= sf_cnt + 1'b1;
        end
      end
    end
  end

  assign out_v   = out_v_q;
  assign out_acc = out_acc_q;

endmodule

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 SHALL have parameter SIMD, default 4: number of product lanes per beat.
REQ-002 SHALL have parameter SF, default 3: number of beats accumulated per output (SF >= 1).
REQ-003 SHALL have parameter TDstI, default 8: signed product width per lane.
REQ-004 SHALL have parameter TDstO, default 16: signed accumulator and output width.
REQ-005 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_v, input, 1: product beat valid.
REQ-008 SHALL have port in_prod, input, SIMD*TDstI: packed signed lane products; lane i occupies bits [i*TDstI +: TDstI].
REQ-009 SHALL have port out_v, output, 1: one-cycle pulse marking a completed dot product.
REQ-010 SHALL have port out_acc, output, TDstO: signed accumulated result.

Function
REQ-011 SHALL consume the products emitted by the PE SIMD lanes and reduce them to one dot product every SF valid beats.
REQ-012 SHALL treat all lanes as signed and sign-extend each to TDstI+$clog2(SIMD) bits before summation.
REQ-013 Stage 1: on each edge with in_v=1, SHALL register the lane sum in sum_r and set sum_v=1; with in_v=0, sum_v SHALL be 0 and sum_r SHALL hold.
REQ-014 Stage 2: on each edge with sum_v=1, SHALL update acc as (beat index 0 ? 0 : acc) + sign-extended sum_r.
REQ-015 SHALL keep a beat counter sf_cnt, range 0..SF-1, that increments only when sum_v=1 and wraps to 0 after SF-1.
REQ-016 On the edge where sum_v=1 and sf_cnt=SF-1, SHALL load out_acc with the final sum and assert out_v for exactly one cycle.
REQ-017 Latency SHALL be 2 cycles: out_v is high in the second cycle after the edge that sampled the SF-th beat.
REQ-018 out_acc SHALL hold its value until the next completion.
REQ-019 Gaps in in_v SHALL stall the counter and accumulator without loss or corruption.
REQ-020 With back-to-back beats, the first beat of the next group SHALL start from 0 in the cycle after completion, so no partial sum carries over.
REQ-021 SF=1 SHALL produce one output per valid beat.
REQ-022 SHALL provide no backpressure: the downstream consumer always accepts out_v.

Reset
REQ-023 rst=1 SHALL clear sum_r, sum_v, acc, sf_cnt, out_acc and out_v to 0 on the next edge.
REQ-024 Reset asserted mid-group SHALL discard the partial sum; the next beat after reset is beat index 0.
REQ-025 Beats presented while rst=1 SHALL be ignored.

Configuration
REQ-026 With MVU_PE_ACC_SAT_EN defined, SHALL clamp every accumulator update to [-2^(TDstO-1), 2^(TDstO-1)-1].
REQ-027 Without MVU_PE_ACC_SAT_EN, accumulation SHALL wrap modulo 2^TDstO (two's complement).

Structure
REQ-028 SIMD, SF, TDstI and TDstO defaults, plus the derived sum width constant, SHALL live in the shared package mvau_pkg.
REQ-029 The SIMD-lane reduction SHALL be a sub-module mvu_pe_adders: combinational tree, registered by the parent's stage 1.
REQ-030 The counter and accumulator SHALL be in mvu_pe_acc.

Verification
All scenarios use SIMD=4, SF=3, TDstI=8, TDstO=16 unless stated.
REQ-031 Three consecutive beats with all lanes = 1 -> one out_v pulse 2 cycles after the third beat, out_acc=12.
REQ-032 Three beats of lanes {2,-1,3,0}, each separated by 2 idle cycles -> out_acc=12; out_v only after the third beat.
REQ-033 Six back-to-back beats, lane sum 5 for three beats then -2 for three -> out_acc=15 then -6, pulses 3 cycles apart.
REQ-034 rst asserted after 2 beats of lane sum 7, then three beats of all lanes = 1 -> out_acc=12; out_v=0 and out_acc=0 during and after reset until completion.
REQ-035 TDstO=10, three beats of all lanes = 127 -> out_acc=511 with MVU_PE_ACC_SAT_EN; out_acc=500 (1524 mod 1024) without it.
REQ-036 SF=1, beats with lane sums 3, -4, 0 -> three out_v pulses with out_acc = 3, -4, 0.
